// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one spi_master between NREQ requesters.
//   A requester is granted in IDLE when the master is idle (m_load=1). Its TX word is latched
//   onto m_din, m_st is pulsed for one cycle, and the arbiter then follows m_load low (frame
//   shifting) and back high (frame ended). On that cycle m_dout is captured into rx_dat and
//   the owner gets a one-cycle done strobe. The owner's successor becomes highest priority.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to bound each frame to TIMEOUT wait cycles.
//   On expiry the frame is aborted: err sets (sticky until rst), rx_dat keeps its old value,
//   and done still pulses to the owner. Without the macro err is tied low.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   req     per-requester request, held until its done
//   tx_dat  packed TX words, requester i at [i*WIDTH +: WIDTH]
//   gnt     one-hot owner of the current frame
//   done    one-cycle completion strobe to the owner, rx_dat valid that cycle
//   rx_dat  last received word
//   m_st    one-cycle start pulse to spi_master
//   m_din   TX word to spi_master, stable for the whole frame
//   m_dout  RX word from spi_master
//   m_load  spi_master idle flag (1 idle, 0 shifting)
//   busy    arbiter is not in IDLE
//   err     sticky frame timeout flag
module spi_xfer_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 13,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] tx_dat,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      rx_dat,
  output logic                  m_st,
  output logic [WIDTH-1:0]      m_din,
  input  logic [WIDTH-1:0]      m_dout,
  input  logic                  m_load,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned IdxW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || TIMEOUT < 2) begin : g_bad_param
    $error("spi_xfer_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitLo,
    StWaitHi,
    StDone
  } state_e;

  state_e           state_q;
  logic [IdxW-1:0]  ptr_q;
  logic [IdxW-1:0]  idx_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  done_q;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] din_q;
  logic             st_q;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;
  logic            err_q;
  logic            to_hit;
  // Counter holds the number of wait cycles already spent; this cycle is the TIMEOUT-th.
  assign to_hit = (cnt_q == CntW'(TIMEOUT - 1));
`endif

  // Round-robin search: indices at or above ptr_q beat those below it, and within each
  // group the lowest index wins. Loops run high-to-low so the lowest match is written last.
  logic            pick_vld;
  logic [IdxW-1:0] pick_idx;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req[k] && (k < int'(ptr_q))) begin
        pick_vld = 1'b1;
        pick_idx = k[IdxW-1:0];
      end
    end
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req[k] && (k >= int'(ptr_q))) begin
        pick_vld = 1'b1;
        pick_idx = k[IdxW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rx_q    <= '0;
      din_q   <= '0;
      st_q    <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      st_q   <= 1'b0;
      done_q <= '0;
      unique case (state_q)
        StIdle: begin
          // m_load low here means someone else is driving the master; do not start.
          if (pick_vld && m_load) begin
            gnt_q   <= NREQ'(1) << pick_idx;
            idx_q   <= pick_idx;
            din_q   <= tx_dat[pick_idx*WIDTH +: WIDTH];
            st_q    <= 1'b1;
            state_q <= StStart;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StStart: begin
          state_q <= StWaitLo;
        end
        StWaitLo: begin
          if (!m_load) begin
            state_q <= StWaitHi;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (to_hit) begin
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= StDone;
          end
          cnt_q <= cnt_q + CntW'(1);
`endif
        end
        StWaitHi: begin
          if (m_load) begin
            rx_q    <= m_dout;
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= StDone;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (to_hit) begin
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= StDone;
          end
          cnt_q <= cnt_q + CntW'(1);
`endif
        end
        StDone: begin
          // Owner's successor gets top priority so a re-requesting owner goes last.
          ptr_q   <= (idx_q == IdxW'(NREQ - 1)) ? '0 : idx_q + IdxW'(1);
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rx_dat = rx_q;
  assign m_st   = st_q;
  assign m_din  = din_q;
  assign busy   = (state_q != StIdle);
`ifdef SPI_ARB_TIMEOUT_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: a transaction-level requester/slave model drives the DUT at
// negedges and predicts grants, strobes and RX words from the round-robin rules.
module tb_spi_xfer_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned WIDTH   = 13;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [WIDTH-1:0] RespMask = 13'h1140;  // slave returns din ^ RespMask

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] tx_dat;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      rx_dat;
  logic                  m_st;
  logic [WIDTH-1:0]      m_din;
  logic [WIDTH-1:0]      m_dout;
  logic                  m_load;
  logic                  busy;
  logic                  err;

  spi_xfer_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .tx_dat (tx_dat),
    .gnt    (gnt),
    .done   (done),
    .rx_dat (rx_dat),
    .m_st   (m_st),
    .m_din  (m_din),
    .m_dout (m_dout),
    .m_load (m_load),
    .busy   (busy),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state
  logic [WIDTH-1:0] tx [NREQ];
  int               ptr;
  int               owner;
  bit               in_frame;
  bit               exp_done;
  bit               exp_idle;
  bit               could_grant;
  bit               rand_on;
  bit               hold_all;
  bit               sl_hang;
  logic [WIDTH-1:0] exp_din;
  logic [WIDTH-1:0] exp_rx;
  int               sl_phase;
  int               sl_cnt;
  int               sl_ext;
  int               hi_n;
  int               n_resets;
  int               glog[$];

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < int'(NREQ); k++) begin
      if (r[(p + k) % int'(NREQ)]) return (p + k) % int'(NREQ);
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  task automatic refresh();
    for (int i = 0; i < int'(NREQ); i++) tx_dat[i*WIDTH +: WIDTH] = tx[i];
    could_grant = !in_frame && !exp_done && (req != '0) && m_load && !rst;
  endtask

  // One negedge of the model: check what the DUT shows, then advance stimulus.
  task automatic step();
    int o;
    if (exp_done || done != '0) begin
      check("done", 32'(done), exp_done ? 32'(onehot(owner)) : 32'd0);
      if (exp_done) begin
        check("rx_dat", 32'(rx_dat), 32'(exp_rx));
        check("gnt_clr", 32'(gnt), 32'd0);
        ptr        = (owner + 1) % int'(NREQ);
        req[owner] = hold_all;
        exp_done   = 1'b0;
        exp_idle   = 1'b1;
        sl_phase   = 0;
      end
    end else if (exp_idle) begin
      check("busy_idle", 32'(busy), 32'd0);
      exp_idle = 1'b0;
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (could_grant || gnt != '0 || m_st) begin
        o = pick(req, ptr);
        check("gnt", 32'(gnt), could_grant ? 32'(onehot(o)) : 32'd0);
        check("m_st", 32'(m_st), 32'(could_grant));
        if (could_grant) begin
          check("m_din", 32'(m_din), 32'(tx[o]));
          owner    = o;
          in_frame = 1'b1;
          exp_din  = tx[o];
          glog.push_back(o);
          sl_phase = 1;
          sl_cnt   = $urandom_range(0, 2);
        end
      end
    end else if (m_st) begin
      check("m_st_frame", 32'(m_st), 32'd0);
    end

    // Slave model
    case (sl_phase)
      1: begin
        if (!sl_hang) begin
          if (sl_cnt == 0) begin
            m_load   = 1'b0;
            sl_cnt   = $urandom_range(2, 6);
            sl_phase = 2;
            hi_n     = 0;
          end else begin
            sl_cnt--;
          end
        end
      end
      2: begin
        hi_n++;
        if (rand_on && hi_n >= 2 && n_resets < 3 && $urandom_range(0, 5) == 0) begin
          // DUT sits in WAIT_HI: reset it mid-frame.
          n_resets++;
          rst = 1'b1;
          @(negedge clk);
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_gnt", 32'(gnt), 32'd0);
          check("rst_done", 32'(done), 32'd0);
          check("rst_rx", 32'(rx_dat), 32'd0);
          check("rst_m_st", 32'(m_st), 32'd0);
          rst      = 1'b0;
          m_load   = 1'b1;
          ptr      = 0;
          in_frame = 1'b0;
          sl_phase = 0;
        end else begin
          sl_cnt--;
          if (sl_cnt == 0) begin
            check("m_din_hold", 32'(m_din), 32'(exp_din));
            m_load   = 1'b1;
            m_dout   = exp_din ^ RespMask;
            exp_rx   = exp_din ^ RespMask;
            exp_done = 1'b1;
            sl_phase = 3;
          end
        end
      end
      default: ;
    endcase

    if (rand_on) begin
      if (in_frame && sl_phase != 0 && !exp_done) begin
        if ($urandom_range(0, 7) == 0) tx[owner] = WIDTH'($urandom);
        if ($urandom_range(0, 15) == 0) req[owner] = 1'b0;
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!req[i] && !(in_frame && i == owner) && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          tx[i]  = WIDTH'($urandom);
        end
      end
      if (sl_ext > 0) begin
        sl_ext--;
        if (sl_ext == 0) m_load = 1'b1;
      end else if (!in_frame && !exp_idle && !exp_done && $urandom_range(0, 31) == 0) begin
        m_load = 1'b0;
        sl_ext = $urandom_range(1, 4);
      end
    end
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step();
    end
  endtask

  initial begin
    int k;
    logic [WIDTH-1:0] rx_keep;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; req = '0; tx_dat = '0; m_load = 1'b1; m_dout = '0;
    for (int i = 0; i < int'(NREQ); i++) tx[i] = '0;
    ptr = 0; owner = 0; in_frame = 0; exp_done = 0; exp_idle = 0; could_grant = 0;
    rand_on = 0; hold_all = 0; sl_hang = 0; sl_phase = 0; sl_cnt = 0; sl_ext = 0;
    hi_n = 0; n_resets = 0; exp_din = '0; exp_rx = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt0", 32'(gnt), 32'd0);
    check("rst_done0", 32'(done), 32'd0);
    check("rst_rx0", 32'(rx_dat), 32'd0);
    check("rst_m_st0", 32'(m_st), 32'd0);
    check("rst_m_din0", 32'(m_din), 32'd0);
    check("rst_busy0", 32'(busy), 32'd0);
    check("rst_err0", 32'(err), 32'd0);
    rst = 1'b0;

    // Single requester 0
    tx[0] = 13'h1DAD;
    req   = 4'b0001;
    refresh();
    run(20);
    check("t1_rx", 32'(rx_dat), 32'h0CED);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_n", glog.size(), 1);

    // req=0101 with priority pointer at 1: 2 then 0
    glog.delete();
    tx[0] = 13'h0A5A; tx[2] = 13'h15A5;
    req   = 4'b0101;
    refresh();
    run(40);
    check("t3_n", glog.size(), 2);
    if (glog.size() == 2) begin
      check("t3_first", glog[0], 2);
      check("t3_second", glog[1], 0);
    end

    // All four held continuously, pointer at 1
    glog.delete();
    for (int i = 0; i < int'(NREQ); i++) tx[i] = WIDTH'(13'h100 + i);
    hold_all = 1'b1;
    req      = 4'b1111;
    refresh();
    for (int i = 0; i < 200 && glog.size() < 5; i++) run(1);
    hold_all = 1'b0;
    check("t2_n", glog.size(), 5);
    if (glog.size() >= 5) begin
      check("t2_g0", glog[0], 1);
      check("t2_g1", glog[1], 2);
      check("t2_g2", glog[2], 3);
      check("t2_g3", glog[3], 0);
      check("t2_g4", glog[4], 1);
    end
    req = '0;
    refresh();
    run(20);

    // Randomised traffic with drops, tx changes, external busy and mid-frame resets
    rand_on = 1'b1;
    run(5000);
    rand_on = 1'b0;
    check("rand_resets", 32'(n_resets > 0), 32'd1);
    for (int i = 0; i < 40 && (in_frame || exp_done || exp_idle); i++) run(1);
    if (sl_ext > 0) begin
      sl_ext = 0;
      m_load = 1'b1;
    end
    req = '0;
    refresh();
    run(5);
    check("err_clean", 32'(err), 32'd0);

    // Master never responds after m_st
    rx_keep = rx_dat;
    sl_hang = 1'b1;
    tx[1]   = 13'h0F0F;
    req     = 4'b0010;
    refresh();
    for (int i = 0; i < 20 && !in_frame; i++) run(1);
    check("hang_grant", 32'(in_frame), 32'd1);
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done != '0) break;
    end
`ifdef SPI_ARB_TIMEOUT_EN
    check("to_latency", k, TIMEOUT + 1);
    check("to_done", 32'(done), 32'h2);
    check("to_rx", 32'(rx_dat), 32'(rx_keep));
    check("to_err", 32'(err), 32'd1);
    req = '0;
    repeat (10) @(negedge clk);
    check("to_err_sticky", 32'(err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
`else
    check("hang_done", 32'(done), 32'd0);
    check("hang_busy", 32'(busy), 32'd1);
    check("hang_gnt", 32'(gnt), 32'h2);
    check("hang_err", 32'(err), 32'd0);
    check("hang_rx", 32'(rx_dat), 32'(rx_keep));
`endif
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);
    check("final_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
